// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM encoding and sizing helpers for the DMA burst controller
package dma_pkg;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [63:0] io_addr_default(input int aw);
        return (64'd1 << aw) - 64'd1;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin pick starting just after the last grant
module dma_rr_arbiter import dma_pkg::*; #(
    parameter int CHANNELS = 2,
    parameter int IW       = idx_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IW-1:0]       last,
    output logic [CHANNELS-1:0] gnt,
    output logic [IW-1:0]       gnt_idx,
    output logic                valid
);

    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            c = (int'(last) + i) % CHANNELS;
            if (!valid && req[c]) begin
                valid   = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: multi-channel DMA moving peripheral words into data memory, skipping the I/O address
module dma_burst_ctrl import dma_pkg::*; #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                CHANNELS = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR  = ADDR_W'(io_addr_default(ADDR_W))
) (
    input  logic                          clock_reg,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           ch_req,
    input  logic [CHANNELS*DATA_W-1:0]    ch_data,
    output logic [CHANNELS-1:0]           ch_ack,
    input  logic                          cfg_we,
    input  logic [$clog2(CHANNELS)-1:0]   cfg_sel,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [ADDR_W-1:0]             cfg_len,
    output logic [CHANNELS-1:0]           ch_en,
    output logic [CHANNELS-1:0]           done,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready
);

    localparam int IW = idx_w(CHANNELS);

    function automatic logic [ADDR_W-1:0] skip_io(input logic [ADDR_W-1:0] a);
        return (a == IO_ADDR) ? a + 1'b1 : a;
    endfunction

    state_t                     state_q, state_d;
    logic [IW-1:0]              grant_q, grant_d, last_q, last_d;
    logic                       mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]          mem_wdata_q, mem_wdata_d;
    logic [CHANNELS-1:0]        ch_ack_q, ch_ack_d, done_q, done_d;
    logic [CHANNELS-1:0]        en_vec;
    logic [CHANNELS*ADDR_W-1:0] addr_flat, cnt_flat;
    logic [CHANNELS-1:0]        arb_gnt;
    logic [IW-1:0]              arb_idx;
    logic                       arb_valid;
    logic                       accept;

    assign accept = (state_q == WRITE) && mem_ready;

    dma_rr_arbiter #(.CHANNELS(CHANNELS), .IW(IW)) u_arb (
        .req     (ch_req & en_vec),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
        logic              en_q, en_d, arm, fin;
        // Arming and completion are exclusive: arming needs the channel idle, completion needs it busy
        always_comb begin
            arm    = cfg_we && (cfg_len != '0) && !en_q && (cfg_sel == IW'(i));
            fin    = accept && (grant_q == IW'(i));
            addr_d = arm ? skip_io(cfg_base) : fin ? skip_io(addr_q + 1'b1) : addr_q;
            cnt_d  = arm ? cfg_len : fin ? cnt_q - 1'b1 : cnt_q;
            en_d   = arm | (en_q & ~(fin && (cnt_q == ADDR_W'(1))));
        end
        always_ff @(posedge clock_reg or negedge reset) begin
            if (!reset) begin
                addr_q <= '0;
                cnt_q  <= '0;
                en_q   <= 1'b0;
            end else begin
                addr_q <= addr_d;
                cnt_q  <= cnt_d;
                en_q   <= en_d;
            end
        end
        assign en_vec[i]                      = en_q;
        assign addr_flat[i*ADDR_W +: ADDR_W]  = addr_q;
        assign cnt_flat[i*ADDR_W +: ADDR_W]   = cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ch_ack_d    = '0;
        done_d      = '0;
        if (state_q == IDLE && arb_valid) begin
            state_d     = WRITE;
            grant_d     = arb_idx;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_flat[int'(arb_idx)*ADDR_W +: ADDR_W];
            mem_wdata_d = ch_data[int'(arb_idx)*DATA_W +: DATA_W];
            ch_ack_d    = arb_gnt;
        end else if (accept) begin
            state_d         = IDLE;
            mem_we_d        = 1'b0;
            last_d          = grant_q;
            done_d[grant_q] = cnt_flat[int'(grant_q)*ADDR_W +: ADDR_W] == ADDR_W'(1);
        end
    end

    // Last-grant resets to the top channel so channel 0 wins first
    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(CHANNELS - 1);
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ch_ack_q    <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ch_ack_q    <= ch_ack_d;
            done_q      <= done_d;
        end
    end

    assign ch_en     = en_vec;
    assign ch_ack    = ch_ack_q;
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// tb_dma_burst_ctrl: directed bursts with a write scoreboard checked by a separate monitor
module tb_dma_burst_ctrl;

    logic        clock_reg = 1'b0;
    logic        reset     = 1'b0;
    logic [1:0]  ch_req    = '0;
    logic [15:0] ch_data   = '0;
    logic [1:0]  ch_ack, ch_en, done;
    logic        cfg_we    = 1'b0;
    logic        cfg_sel   = 1'b0;
    logic [7:0]  cfg_base  = '0;
    logic [7:0]  cfg_len   = '0;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_ready = 1'b1;

    dma_burst_ctrl dut (
        .clock_reg (clock_reg),
        .reset     (reset),
        .ch_req    (ch_req),
        .ch_data   (ch_data),
        .ch_ack    (ch_ack),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .ch_en     (ch_en),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    always #5 clock_reg = ~clock_reg;

    logic [15:0] exp_q[$];
    int n_cmp = 0, n_bad = 0, n_wr = 0;
    int ack_n[2] = '{0, 0};
    int done_n[2] = '{0, 0};
    int a0, a1, d0, d1, w0, k;
    logic       prev_we = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_addr = '0, prev_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted write and checks hold under backpressure
    always @(negedge clock_reg) begin
        logic [15:0] e;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                if (ch_ack[c]) ack_n[c]++;
                if (done[c]) done_n[c]++;
            end
            if (prev_we && !prev_rdy) begin
                check("hold_we", mem_we, 1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_data", mem_wdata, prev_data);
            end
            if (mem_we) check("io_skip", mem_addr == 8'hFF, 0);
            if (mem_we && mem_ready) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %0h with nothing expected", {mem_addr, mem_wdata});
                end else begin
                    e = exp_q.pop_front();
                    check("write", {mem_addr, mem_wdata}, e);
                end
            end
        end
        prev_we   <= reset ? mem_we : 1'b0;
        prev_rdy  <= mem_ready;
        prev_addr <= mem_addr;
        prev_data <= mem_wdata;
    end

    task automatic step();
        @(posedge clock_reg);
        #1;
    endtask

    task automatic prog(input logic sel, input logic [7:0] base, input logic [7:0] len);
        cfg_sel  = sel;
        cfg_base = base;
        cfg_len  = len;
        cfg_we   = 1'b1;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (ch_en != 0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("idle_timeout", ch_en, 0);
    endtask

    task automatic wait_we(input string nm);
        int n = 0;
        while (!mem_we && n < 20) begin
            step();
            n++;
        end
        check(nm, mem_we, 1);
    endtask

    task automatic snap();
        a0 = ack_n[0];
        a1 = ack_n[1];
        d0 = done_n[0];
        d1 = done_n[1];
        w0 = n_wr;
    endtask

    task automatic tally(input string nm, input int ea0, input int ea1, input int ed0, input int ed1, input int ew);
        check({nm, "_ack0"}, ack_n[0] - a0, ea0);
        check({nm, "_ack1"}, ack_n[1] - a1, ea1);
        check({nm, "_done0"}, done_n[0] - d0, ed0);
        check({nm, "_done1"}, done_n[1] - d1, ed1);
        check({nm, "_writes"}, n_wr - w0, ew);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_we"}, mem_we, 0);
        check({nm, "_addr"}, mem_addr, 0);
        check({nm, "_wdata"}, mem_wdata, 0);
        check({nm, "_en"}, ch_en, 0);
        check({nm, "_ack"}, ch_ack, 0);
        check({nm, "_done"}, done, 0);
    endtask

    initial begin
        repeat (2) step();
        check_zero("reset");
        reset = 1'b1;
        step();

        // single channel, 3 words from 0x10
        snap();
        ch_data[7:0] = 8'h5A;
        ch_req = 2'b01;
        exp_q.push_back(16'h105A);
        exp_q.push_back(16'h115A);
        exp_q.push_back(16'h125A);
        prog(0, 8'h10, 8'd3);
        check("t1_no_early_grant", mem_we, 0);
        check("t1_armed", ch_en, 2'b01);
        wait_idle(k);
        check("t1_cycles", k, 6);
        ch_req = 2'b00;
        step();
        tally("t1", 3, 0, 1, 0, 3);

        // wrap past the top of memory skipping the I/O address
        snap();
        ch_data[7:0] = 8'h3C;
        ch_req = 2'b01;
        exp_q.push_back(16'hFD3C);
        exp_q.push_back(16'hFE3C);
        exp_q.push_back(16'h003C);
        prog(0, 8'hFD, 8'd3);
        wait_idle(k);
        ch_req = 2'b00;
        step();
        tally("t2", 3, 0, 1, 0, 3);

        // base on the I/O address starts one above it
        snap();
        ch_data[7:0] = 8'h99;
        ch_req = 2'b01;
        exp_q.push_back(16'h0099);
        exp_q.push_back(16'h0199);
        prog(0, 8'hFF, 8'd2);
        wait_idle(k);
        ch_req = 2'b00;
        step();
        tally("t3", 2, 0, 1, 0, 2);

        // two channels after reset alternate starting with channel 0
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        snap();
        ch_data = 16'hB2A1;
        ch_req = 2'b11;
        exp_q.push_back(16'h20A1);
        exp_q.push_back(16'h30B2);
        exp_q.push_back(16'h21A1);
        exp_q.push_back(16'h31B2);
        prog(0, 8'h20, 8'd2);
        prog(1, 8'h30, 8'd2);
        wait_idle(k);
        ch_req = 2'b00;
        step();
        tally("t4", 2, 2, 1, 1, 4);

        // backpressure: four cycles of mem_ready low on the first word
        snap();
        ch_data[7:0] = 8'h77;
        ch_req = 2'b01;
        mem_ready = 1'b0;
        exp_q.push_back(16'h5077);
        exp_q.push_back(16'h5177);
        prog(0, 8'h50, 8'd2);
        wait_we("t5_we_seen");
        repeat (4) step();
        mem_ready = 1'b1;
        wait_idle(k);
        ch_req = 2'b00;
        step();
        tally("t5", 2, 0, 1, 0, 2);

        // reprogramming a busy channel is ignored
        snap();
        ch_data[7:0] = 8'h11;
        ch_req = 2'b01;
        exp_q.push_back(16'h6011);
        exp_q.push_back(16'h6111);
        exp_q.push_back(16'h6211);
        prog(0, 8'h60, 8'd3);
        k = 0;
        while (!ch_ack[0] && k < 20) begin
            step();
            k++;
        end
        check("t6_ack_seen", ch_ack[0], 1);
        prog(0, 8'h40, 8'd5);
        wait_idle(k);
        ch_req = 2'b00;
        step();
        tally("t6", 3, 0, 1, 0, 3);

        // zero length never arms
        snap();
        ch_data[15:8] = 8'hC3;
        ch_req = 2'b10;
        prog(1, 8'h70, 8'd0);
        repeat (5) step();
        check("t7_en", ch_en, 0);
        ch_req = 2'b00;
        tally("t7", 0, 0, 0, 0, 0);

        // reset in the middle of a stalled write
        ch_data[7:0] = 8'h55;
        ch_req = 2'b01;
        mem_ready = 1'b0;
        exp_q.push_back(16'h8055);
        prog(0, 8'h80, 8'd3);
        wait_we("t8_we_seen");
        #2 reset = 1'b0;
        #1 check_zero("t8_async");
        exp_q.delete();
        mem_ready = 1'b1;
        step();
        reset = 1'b1;
        snap();
        repeat (6) step();
        check("t8_en_after", ch_en, 0);
        tally("t8", 0, 0, 0, 0, 0);
        ch_req = 2'b00;

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
